i2s_tx_ctrl: RTL and testbench

Timing controller and sample scheduler for the 16-bit stereo parallel-to-serial converter on the audio transmit path. From the single MCLK it generates the bit-clock enable strobe, the left and right latch strobes, the external BCLK and LRCK pins, and the per-frame LDATA/RDATA words. It also buffers one stereo sample from the upstream audio source through a valid/ready handshake. Together with the converter it forms a complete I2S transmitter; MCLK runs at 256·fs with the default parameters.

---
 rtl/i2s_tx_ctrl.sv | 179 +++++++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: I2S transmit timing controller and single-sample scheduler.
// Generates the BCLK shift strobe, latch strobes, BCLK/LRCK pins and per-frame
// LDATA/RDATA words from MCLK, and buffers one stereo sample via valid/ready.
// Build option: I2S_TX_MUTE_ON_UNDERRUN_EN zeroes LDATA/RDATA on an underrun
// frame load; without it the previous sample repeats.
module i2s_tx_ctrl #(
    parameter int unsigned MCLK_DIV  = 4,
    parameter int unsigned SLOT_BITS = 32
) (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic [15:0] L_IN,
    input  logic [15:0] R_IN,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    output logic        SAMPLE_REQ,
    output logic [15:0] LDATA,
    output logic [15:0] RDATA,
    output logic        LATCH_L,
    output logic        LATCH_R,
    output logic        BCLK,
    output logic        BCLK_PIN,
    output logic        LRCK,
    output logic        UNDERRUN,
    input  logic        UNDERRUN_CLR
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned DIV_W    = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
    localparam int unsigned BIT_W    = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

    // phase state
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                side_q, side_d;

    // registered strobes and pins
    logic                req_q, req_d;
    logic                latch_l_q, latch_l_d;
    logic                latch_r_q, latch_r_d;
    logic                bclk_q, bclk_d;
    logic                bclk_pin_q, bclk_pin_d;
    logic                lrck_q, lrck_d;

    // sample path
    logic                full_q, full_d;
    logic                ready_q, ready_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0] ldata_q, ldata_d;
    logic [SAMPLE_W-1:0] rdata_q, rdata_d;
    logic                underrun_q, underrun_d;

    logic                frame_last;
    logic                capture;

    // Next phase, and strobes decoded from it so each flop lines up with its phase
    always_comb begin
        div_d      = '0;
        bit_d      = '0;
        side_d     = 1'b0;
        req_d      = 1'b0;
        latch_l_d  = 1'b0;
        latch_r_d  = 1'b0;
        bclk_d     = 1'b0;
        bclk_pin_d = 1'b0;
        lrck_d     = 1'b0;
        if (ENABLE) begin
            div_d  = div_q + DIV_W'(1);
            bit_d  = bit_q;
            side_d = side_q;
            if (div_q == DIV_LAST) begin
                div_d = '0;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_LAST) begin
                    bit_d  = '0;
                    side_d = ~side_q;
                end
            end
            req_d      = (div_d == '0) && (bit_d == '0) && !side_d;
            latch_l_d  = !side_d && (bit_d == '0) && (div_d == DIV_LAST);
            latch_r_d  = side_d && (bit_d == '0) && (div_d == DIV_LAST);
            bclk_d     = (div_d == DIV_LAST) && (bit_d != '0);
            bclk_pin_d = (div_d >= DIV_HALF);
            lrck_d     = side_d;
        end
    end

    // Hold-buffer handshake, frame load and sticky underrun
    always_comb begin
        frame_last = ENABLE && side_q && (bit_q == BIT_LAST) && (div_q == DIV_LAST);
        capture    = SAMPLE_VALID && !full_q;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        ldata_d    = ldata_q;
        rdata_d    = rdata_q;
        underrun_d = UNDERRUN_CLR ? 1'b0 : underrun_q;
        if (capture) begin
            hold_l_d = L_IN;
            hold_r_d = R_IN;
            full_d   = 1'b1;
        end
        if (frame_last) begin
            if (full_q) begin
                ldata_d = hold_l_q;
                rdata_d = hold_r_q;
                full_d  = 1'b0;
            end else begin
                // an arriving sample still lands in the hold buffer for the next frame
                underrun_d = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                ldata_d = '0;
                rdata_d = '0;
`else
                ldata_d = ldata_q;
                rdata_d = rdata_q;
`endif
            end
        end
        ready_d = !full_d;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            div_q      <= '0;
            bit_q      <= '0;
            side_q     <= 1'b0;
            req_q      <= 1'b0;
            latch_l_q  <= 1'b0;
            latch_r_q  <= 1'b0;
            bclk_q     <= 1'b0;
            bclk_pin_q <= 1'b0;
            lrck_q     <= 1'b0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            ldata_q    <= '0;
            rdata_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            side_q     <= side_d;
            req_q      <= req_d;
            latch_l_q  <= latch_l_d;
            latch_r_q  <= latch_r_d;
            bclk_q     <= bclk_d;
            bclk_pin_q <= bclk_pin_d;
            lrck_q     <= lrck_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            ldata_q    <= ldata_d;
            rdata_q    <= rdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign SAMPLE_READY = ready_q;
    assign SAMPLE_REQ   = req_q;
    assign LDATA        = ldata_q;
    assign RDATA        = rdata_q;
    assign LATCH_L      = latch_l_q;
    assign LATCH_R      = latch_r_q;
    assign BCLK         = bclk_q;
    assign BCLK_PIN     = bclk_pin_q;
    assign LRCK         = lrck_q;
    assign UNDERRUN     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// tb_i2s_tx_ctrl: scoreboard bench for i2s_tx_ctrl with default parameters.
// Honours I2S_TX_MUTE_ON_UNDERRUN_EN for the expected underrun frame words.
module tb_i2s_tx_ctrl;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } frame_t;

    logic        mclk = 1'b0;
    logic        rst_n, enable, sample_valid, underrun_clr;
    logic [15:0] l_in, r_in;
    logic        sample_ready, sample_req, latch_l, latch_r, bclk, bclk_pin, lrck, underrun;
    logic [15:0] ldata, rdata;

    int          tests = 0;
    int          fails = 0;

    frame_t      exp_q[$];
    frame_t      cur;

    // bench timing model: linear frame index of the current cycle
    int unsigned ep    = 0;
    bit          act   = 1'b0;
    bit          mfull = 1'b0;
    bit          mon_on = 1'b0;
    bit          cap;
    bit          l_pend = 1'b0;
    bit          r_pend = 1'b0;
    logic [15:0] sh, col;
    int          nb;
    logic [6:0]  exp_v, dut_v;

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    localparam logic [15:0] REP_L = 16'h0000;
    localparam logic [15:0] REP_R = 16'h0000;
`else
    localparam logic [15:0] REP_L = 16'hA55A;
    localparam logic [15:0] REP_R = 16'h1234;
`endif

    i2s_tx_ctrl dut (
        .MCLK         (mclk),
        .RST_N        (rst_n),
        .ENABLE       (enable),
        .L_IN         (l_in),
        .R_IN         (r_in),
        .SAMPLE_VALID (sample_valid),
        .SAMPLE_READY (sample_ready),
        .SAMPLE_REQ   (sample_req),
        .LDATA        (ldata),
        .RDATA        (rdata),
        .LATCH_L      (latch_l),
        .LATCH_R      (latch_r),
        .BCLK         (bclk),
        .BCLK_PIN     (bclk_pin),
        .LRCK         (lrck),
        .UNDERRUN     (underrun),
        .UNDERRUN_CLR (underrun_clr)
    );

    initial forever #5 mclk = ~mclk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    // Monitor: compares strobes every cycle, pops a frame entry on each LATCH_L
    always @(negedge mclk) begin
        if (mon_on) begin
            if (act)
                exp_v = {ep == 0, ep == 3, ep == 131,
                         (ep % 4 == 3) && ((ep / 4) % 32 != 0),
                         (ep % 4) >= 2, ep >= 128, !mfull};
            else
                exp_v = {6'b0, !mfull};
            dut_v = {sample_req, latch_l, latch_r, bclk, bclk_pin, lrck, sample_ready};
            check("strobes{req,latL,latR,bclk,pin,lrck,rdy}", 32'(dut_v), 32'(exp_v));

            if (bclk) begin
                if (nb < 16) col = {col[14:0], sh[15]};
                sh = {sh[14:0], 1'b0};
                nb++;
            end
            if (latch_r) begin
                if (l_pend) check("sdata_left", 32'(col), 32'(cur.l));
                sh = rdata; col = '0; nb = 0;
                l_pend = 1'b0;
                r_pend = 1'b1;
            end
            if (latch_l) begin
                if (r_pend) check("sdata_right", 32'(col), 32'(cur.r));
                r_pend = 1'b0;
                l_pend = 1'b0;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL frame: unexpected LATCH_L, queue empty at %0t", $time);
                end else begin
                    tests--;
                    cur = exp_q.pop_front();
                    check("frame_ldata", 32'(ldata), 32'(cur.l));
                    check("frame_rdata", 32'(rdata), 32'(cur.r));
                    check("frame_underrun", 32'(underrun), 32'(cur.und));
                    l_pend = 1'b1;
                end
                sh = ldata; col = '0; nb = 0;
            end
        end

        // advance model with the inputs sampled at the coming edge
        if (!rst_n) begin
            ep = 0; act = 1'b0; mfull = 1'b0; l_pend = 1'b0; r_pend = 1'b0;
        end else begin
            cap = sample_valid && !mfull;
            if (act && ep == 255 && enable) mfull = cap;
            else if (cap) mfull = 1'b1;
            if (enable) begin
                ep  = (ep + 1) % 256;
                act = 1'b1;
            end else begin
                ep = 0; act = 1'b0; l_pend = 1'b0; r_pend = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic go_to(input int unsigned t);
        int n = 0;
        while (ep != t && n < 1000) begin
            step();
            n++;
        end
        if (ep != t) begin
            tests++;
            fails++;
            $display("FAIL go_to: phase %0d reached, required %0d", ep, t);
        end
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        l_in = l; r_in = r; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
    endtask

    task automatic check_reset_words();
        check("rst_ldata", 32'(ldata), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_ready", 32'(sample_ready), 32'h1);
    endtask

    // Stimulus: directed frame sequence, expected frame words pushed ahead
    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; underrun_clr = 1'b0;
        l_in = '0; r_in = '0;
        repeat (3) step();
        mon_on = 1'b1;
        check_reset_words();

        // frame 0 transmits reset words; nothing offered so frame 1 underruns
        exp_q.push_back('{16'h0000, 16'h0000, 1'b0});
        exp_q.push_back('{16'h0000, 16'h0000, 1'b1});
        rst_n = 1'b1; enable = 1'b1;
        go_to(255);
        step();

        // frame 1: offer after request, clear underrun
        exp_q.push_back('{16'hA55A, 16'h1234, 1'b0});
        go_to(1);
        offer(16'hA55A, 16'h1234);
        go_to(10);
        pulse_clr();
        go_to(255);
        step();

        // frame 2: withheld sample -> underrun
        exp_q.push_back('{REP_L, REP_R, 1'b1});
        go_to(255);
        step();

        // frame 3: clear, then sample and clear coincident with the next underrun
        exp_q.push_back('{REP_L, REP_R, 1'b1});
        exp_q.push_back('{16'hB00C, 16'h0DD1, 1'b1});
        go_to(20);
        pulse_clr();
        go_to(255);
        underrun_clr = 1'b1;
        offer(16'hB00C, 16'h0DD1);
        underrun_clr = 1'b0;
        go_to(255);
        step();

        // frame 5: clear, buffer a sample, abort at p=70
        go_to(20);
        pulse_clr();
        go_to(30);
        offer(16'h5A5A, 16'hC3C3);
        go_to(70);
        enable = 1'b0;
        repeat (4) step();
        exp_q.push_back('{16'hB00C, 16'h0DD1, 1'b0});
        exp_q.push_back('{16'h5A5A, 16'hC3C3, 1'b0});
        enable = 1'b1;
        go_to(255);
        step();

        // frame 7: fill buffer then reset mid-frame with ENABLE held high
        go_to(5);
        offer(16'h1111, 16'h2222);
        go_to(100);
        rst_n = 1'b0;
        step();
        check_reset_words();
        exp_q.push_back('{16'h0000, 16'h0000, 1'b0});
        rst_n = 1'b1;
        go_to(140);
        enable = 1'b0;
        repeat (3) step();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
